// File: rtl/scheduler_mc_if.sv
// Handshake bundle between the scheduler, its memory-return channels, the waiting queue
// and the execution/organisation side.
interface scheduler_mc_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned TID_W  = 4,
    parameter int unsigned DATA_W = 32
);
    logic                    halt;
    logic [NCH-1:0]          ret_valid;
    logic [NCH*TID_W-1:0]    ret_id;
    logic [NCH*DATA_W-1:0]   ret_data;
    logic                    ret_ready;
    logic [TID_W:0]          wait_count;
    logic [TID_W-1:0]        wait_id;
    logic                    wait_pop;
    logic                    issue_valid;
    logic [TID_W-1:0]        issue_id;
    logic                    issue_is_data;
    logic                    operate;
    logic                    deliver_valid;
    logic [TID_W-1:0]        deliver_id;
    logic [DATA_W-1:0]       deliver_data;
    logic                    ovf_err;

    modport master (
        output halt, ret_valid, ret_id, ret_data, wait_count, wait_id,
        input  ret_ready, wait_pop, issue_valid, issue_id, issue_is_data, operate,
               deliver_valid, deliver_id, deliver_data, ovf_err
    );

    modport slave (
        input  halt, ret_valid, ret_id, ret_data, wait_count, wait_id,
        output ret_ready, wait_pop, issue_valid, issue_id, issue_is_data, operate,
               deliver_valid, deliver_id, deliver_data, ovf_err
    );
endinterface

// File: rtl/scheduler_mc.sv
// Thread issue scheduler: buffers multi-channel memory returns in a FIFO, interleaves them
// with waiting-queue threads, and bounds waiting-thread starvation.
module scheduler_mc #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned TID_W      = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DLY        = 1,
    parameter int unsigned RQ_DEPTH   = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    scheduler_mc_if.slave bus
);
    localparam int unsigned PW = $clog2(RQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {SelIdle, SelForce, SelData, SelWait} sel_e;

    logic [TID_W-1:0]  rq_id   [RQ_DEPTH];
    logic [DATA_W-1:0] rq_data [RQ_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d, n_acc;
    logic [SW-1:0]     starve_q, starve_d;
    logic              rst_q;
    logic              ovf_q;
    logic              accept, can_wait, pop;
    logic [NCH-1:0]    wr_en;
    logic [PW-1:0]     wr_addr [NCH];
    sel_e              sel;

    logic              issue_valid_q, issue_valid_d;
    logic              issue_is_data_q, issue_is_data_d;
    logic [TID_W-1:0]  issue_id_q, issue_id_d;
    logic [DATA_W-1:0] issue_data_q, issue_data_d;

    logic              pipe_op   [DLY];
    logic              pipe_dv   [DLY];
    logic [TID_W-1:0]  pipe_id   [DLY];
    logic [DATA_W-1:0] pipe_data [DLY];

    assign bus.ret_ready = (CW'(RQ_DEPTH) - count_q) >= CW'(NCH);
    assign accept        = bus.ret_ready && !rst;

    // Accepted channels pack densely after wr_ptr in ascending channel order.
    always_comb begin
        n_acc = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_en[i]   = accept && bus.ret_valid[i];
            wr_addr[i] = wr_ptr_q + PW'(n_acc);
            if (wr_en[i]) n_acc = n_acc + CW'(1);
        end
    end

    // rst_q holds off waiting-thread issue for the first cycle after reset.
    assign can_wait = !rst && !rst_q && (bus.wait_count != '0) && !bus.halt;

    always_comb begin
        sel = SelIdle;
        if (can_wait && starve_q == SW'(STARVE_MAX)) sel = SelForce;
        else if (count_q != '0)                       sel = SelData;
        else if (can_wait)                            sel = SelWait;
    end

    assign pop          = (sel == SelData);
    assign bus.wait_pop = (sel == SelForce) || (sel == SelWait);

    always_comb begin
        issue_valid_d   = 1'b0;
        issue_is_data_d = 1'b0;
        issue_id_d      = '0;
        issue_data_d    = '0;
        starve_d        = '0;
        unique case (sel)
            SelForce, SelWait: begin
                issue_valid_d = 1'b1;
                issue_id_d    = bus.wait_id;
            end
            SelData: begin
                issue_valid_d   = 1'b1;
                issue_is_data_d = 1'b1;
                issue_id_d      = rq_id[rd_ptr_q];
                issue_data_d    = rq_data[rd_ptr_q];
                starve_d        = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
            end
            default: ;
        endcase
    end

    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign wr_ptr_d = wr_ptr_q + PW'(n_acc);
    assign count_d  = count_q + n_acc - CW'(pop);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (wr_en[i]) begin
                rq_id[wr_addr[i]]   <= bus.ret_id[i*TID_W +: TID_W];
                rq_data[wr_addr[i]] <= bus.ret_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            starve_q        <= '0;
            rst_q           <= 1'b1;
            ovf_q           <= 1'b0;
            issue_valid_q   <= 1'b0;
            issue_is_data_q <= 1'b0;
            issue_id_q      <= '0;
            issue_data_q    <= '0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            starve_q        <= starve_d;
            rst_q           <= 1'b0;
            if (!bus.ret_ready && (bus.ret_valid != '0)) ovf_q <= 1'b1;
            issue_valid_q   <= issue_valid_d;
            issue_is_data_q <= issue_is_data_d;
            issue_id_q      <= issue_id_d;
            issue_data_q    <= issue_data_d;
        end
    end

    // Delivery pipe; id/data are zeroed for non-data issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DLY; k++) begin
                pipe_op[k]   <= 1'b0;
                pipe_dv[k]   <= 1'b0;
                pipe_id[k]   <= '0;
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_op[0]   <= issue_valid_q;
            pipe_dv[0]   <= issue_valid_q && issue_is_data_q;
            pipe_id[0]   <= issue_is_data_q ? issue_id_q : '0;
            pipe_data[0] <= issue_data_q;
            for (int k = 1; k < DLY; k++) begin
                pipe_op[k]   <= pipe_op[k-1];
                pipe_dv[k]   <= pipe_dv[k-1];
                pipe_id[k]   <= pipe_id[k-1];
                pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    assign bus.issue_valid   = issue_valid_q;
    assign bus.issue_id      = issue_id_q;
    assign bus.issue_is_data = issue_is_data_q;
    assign bus.operate       = pipe_op[DLY-1];
    assign bus.deliver_valid = pipe_dv[DLY-1];
    assign bus.deliver_id    = pipe_id[DLY-1];
    assign bus.deliver_data  = pipe_data[DLY-1];
    assign bus.ovf_err       = ovf_q;
endmodule
